// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: buffers core stores in a TX FIFO and feeds
// the transmitter one byte at a time; captures RX bytes and owns the baud divisor.
module uart_mmio_ctrl #(
   parameter int          TX_DEPTH         = 4,
   parameter logic [31:0] UART_RW_ADDR     = 32'h10010000,
   parameter logic [31:0] UART_STATUS_ADDR = 32'h10010005,
   parameter logic [31:0] BAUD_ADDR        = 32'h10010100,
   parameter logic [15:0] BAUD_RESET       = 16'h0003
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        hit,
   output logic [7:0]  uart_data,
   output logic        uart_write_enable,
   input  logic        uart_busy,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_out_valid,
   output logic [15:0] baud_max
);

   localparam int PW = $clog2(TX_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

   tx_state_t   state_reg;
   tx_state_t   state_next;

   logic [7:0]  fifo_mem [TX_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic [7:0]  uart_data_reg;
   logic [15:0] baud_reg;
   logic [7:0]  rx_byte_reg;
   logic        rx_valid_reg;
   logic        rx_overrun_reg;
   logic        tx_overflow_reg;

   logic        sel_rw;
   logic        sel_status;
   logic        sel_baud;
   logic        tx_empty;
   logic        tx_full;
   logic        tx_active;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        rx_clear;
   logic [7:0]  status;
   logic        unused_bits;

   assign unused_bits = ^write_data[31:16];

   // Address decode
   assign sel_rw     = (address == UART_RW_ADDR);
   assign sel_status = (address == UART_STATUS_ADDR);
   assign sel_baud   = (address == BAUD_ADDR);
   assign hit        = sel_rw | sel_status | sel_baud;

   assign tx_empty  = (count_reg == '0);
   assign tx_full   = (count_reg == CW'(TX_DEPTH));
   assign tx_active = (state_reg != IDLE) || !tx_empty;

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   assign pop      = (state_reg == IDLE) && !tx_empty;
   assign push_req = write_enable && sel_rw;
   assign push     = push_req && (!tx_full || pop);
   assign rx_clear = read_enable && sel_rw;

   assign status = {tx_empty, tx_active, tx_full, 2'b00,
                    tx_overflow_reg, rx_overrun_reg, rx_valid_reg};

   always_comb begin
      read_data = 32'h0;
      if (sel_rw)
         read_data = {24'h0, rx_byte_reg};
      else if (sel_status)
         read_data = {24'h0, status};
      else if (sel_baud)
         read_data = {16'h0, baud_reg};
   end

   // FIFO storage: no reset needed, validity is tracked by count
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= write_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Popped byte is held until the next pop
   always_ff @(posedge clk) begin
      if (rst)
         uart_data_reg <= 8'h00;
      else if (pop)
         uart_data_reg <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clk) begin
      if (rst)
         tx_overflow_reg <= 1'b0;
      else if (push_req && tx_full && !pop)
         tx_overflow_reg <= 1'b1;
      else if (write_enable && sel_status && write_data[2])
         tx_overflow_reg <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         baud_reg <= BAUD_RESET;
      else if (write_enable && sel_baud && (write_data[15:0] != 16'h0))
         baud_reg <= write_data[15:0];
   end

   // A clearing read coinciding with a new byte wins for valid but drops overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_byte_reg    <= 8'h00;
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end else if (uart_out_valid) begin
         rx_byte_reg  <= uart_rx_data;
         rx_valid_reg <= 1'b1;
         if (rx_clear)
            rx_overrun_reg <= 1'b0;
         else if (rx_valid_reg)
            rx_overrun_reg <= 1'b1;
      end else if (rx_clear) begin
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (!tx_empty) state_next = LOAD;
         LOAD:      state_next = WAIT_BUSY;
         WAIT_BUSY: if (uart_busy) state_next = WAIT_DONE;
         WAIT_DONE: if (!uart_busy) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      uart_write_enable = (state_reg == LOAD);
   end

   assign uart_data = uart_data_reg;
   assign baud_max  = baud_reg;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: register vector table, TX byte
// scoreboard checked by a UART model, and hand-written multi-cycle sequences.
module tb_uart_mmio_ctrl;

   localparam logic [31:0] RW_A   = 32'h10010000;
   localparam logic [31:0] STAT_A = 32'h10010005;
   localparam logic [31:0] BAUD_A = 32'h10010100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic        read_enable;
   logic [31:0] read_data;
   logic        hit;
   logic [7:0]  uart_data;
   logic        uart_write_enable;
   logic        uart_busy;
   logic [7:0]  uart_rx_data;
   logic        uart_out_valid;
   logic [15:0] baud_max;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulses       = 0;
   int busy_len     = 20;
   int busy_cnt     = 0;
   bit hold_busy    = 1'b0;
   logic [7:0] exp_q[$];
   logic [31:0] rd;

   uart_mmio_ctrl dut (
      .clk(clk), .rst(rst), .address(address), .write_data(write_data),
      .write_enable(write_enable), .read_enable(read_enable),
      .read_data(read_data), .hit(hit), .uart_data(uart_data),
      .uart_write_enable(uart_write_enable), .uart_busy(uart_busy),
      .uart_rx_data(uart_rx_data), .uart_out_valid(uart_out_valid),
      .baud_max(baud_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      address = a; write_data = d; write_enable = 1'b1;
      tick();
      write_enable = 1'b0; address = 32'h0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = read_data;
      address = 32'h0;
   endtask

   task automatic rx_pulse(input logic [7:0] b, input bit clear_read);
      uart_rx_data = b; uart_out_valid = 1'b1;
      if (clear_read) begin
         address = RW_A; read_enable = 1'b1;
      end
      tick();
      uart_out_valid = 1'b0; read_enable = 1'b0; address = 32'h0;
   endtask

   // UART model: each start pulse is matched against the scoreboard, then busy follows
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (busy_cnt != 0) busy_cnt--;
         if (uart_write_enable) begin
            pulses++;
            if (exp_q.size() == 0) begin
               check("tx_unexpected_pulse", {24'h0, uart_data}, 32'hFFFF_FFFF);
            end else begin
               check("tx_byte", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
            end
            busy_cnt = busy_len;
         end
      end
      uart_busy = hold_busy || (busy_cnt != 0);
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] exp_rd;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{STAT_A,        32'h0,         1'b0, 32'h80,   1'b1};
      vecs[1] = '{BAUD_A,        32'h0,         1'b0, 32'h3,    1'b1};
      vecs[2] = '{BAUD_A,        32'hABCD_1234, 1'b1, 32'h3,    1'b1};
      vecs[3] = '{BAUD_A,        32'h0,         1'b0, 32'h1234, 1'b1};
      vecs[4] = '{BAUD_A,        32'hFFFF_0000, 1'b1, 32'h1234, 1'b1};
      vecs[5] = '{BAUD_A,        32'h0,         1'b0, 32'h1234, 1'b1};
      vecs[6] = '{32'h10010004,  32'h0,         1'b0, 32'h0,    1'b0};
      vecs[7] = '{STAT_A,        32'hFFFF_FFFF, 1'b1, 32'h80,   1'b1};
      vecs[8] = '{RW_A,          32'h0,         1'b0, 32'h0,    1'b1};

      rst = 1'b1; address = 32'h0; write_data = 32'h0; write_enable = 1'b0;
      read_enable = 1'b0; uart_rx_data = 8'h0; uart_out_valid = 1'b0; uart_busy = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_uart_we", {31'h0, uart_write_enable}, 32'h0);
      check("rst_uart_data", {24'h0, uart_data}, 32'h0);
      check("rst_baud_max", {16'h0, baud_max}, 32'h3);

      // Register access vectors
      for (int i = 0; i < 9; i++) begin
         address = vecs[i].addr; write_data = vecs[i].wdata;
         write_enable = vecs[i].we; read_enable = 1'b0;
         #1;
         check($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vecs[i].exp_hit});
         tick();
         write_enable = 1'b0;
      end
      check("baud_max_port", {16'h0, baud_max}, 32'h1234);

      // Single byte: start pulse exactly two edges after the store
      busy_len = 20; pulses = 0;
      exp_q.push_back(8'h41);
      bus_write(RW_A, 32'h41);
      check("lat_edge_n_we", {31'h0, uart_write_enable}, 32'h0);
      tick();
      check("lat_edge_n1_we", {31'h0, uart_write_enable}, 32'h1);
      check("lat_edge_n1_data", {24'h0, uart_data}, 32'h41);
      tick();
      check("lat_edge_n2_we", {31'h0, uart_write_enable}, 32'h0);
      repeat (8) tick();
      bus_read(STAT_A, rd);
      check("busy_status", rd, 32'hC0);
      repeat (20) tick();
      bus_read(STAT_A, rd);
      check("after_busy_status", rd, 32'h80);
      check("single_pulse_count", pulses, 1);
      check("single_uart_data_held", {24'h0, uart_data}, 32'h41);

      // FIFO full and overflow while the transmitter is held busy
      busy_len = 3; hold_busy = 1'b1; pulses = 0;
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(8'h10 + 8'(k));
         bus_write(RW_A, 32'h10 + k);
      end
      bus_read(STAT_A, rd);
      check("full_status", rd, 32'h60);
      bus_write(RW_A, 32'hEE);
      bus_read(STAT_A, rd);
      check("overflow_status", rd, 32'h64);
      hold_busy = 1'b0;
      repeat (60) tick();
      check("drain_pulse_count", pulses, 5);
      check("drain_queue_empty", exp_q.size(), 0);
      bus_read(STAT_A, rd);
      check("drain_status", rd, 32'h84);
      bus_write(STAT_A, 32'h4);
      bus_read(STAT_A, rd);
      check("overflow_clear", rd, 32'h80);

      // RX overrun and clearing read
      rx_pulse(8'h55, 1'b0);
      rx_pulse(8'hAA, 1'b0);
      bus_read(RW_A, rd);
      check("rx_byte_aa", rd, 32'hAA);
      bus_read(STAT_A, rd);
      check("rx_overrun_status", rd, 32'h83);
      address = RW_A; read_enable = 1'b1;
      #1;
      check("rx_clearing_read_data", read_data, 32'hAA);
      tick();
      read_enable = 1'b0; address = 32'h0;
      bus_read(STAT_A, rd);
      check("rx_cleared_status", rd, 32'h80);

      // New byte arriving with a clearing read of the old one
      rx_pulse(8'h77, 1'b0);
      address = RW_A;
      #1;
      check("rx_old_byte", read_data, 32'h77);
      rx_pulse(8'h66, 1'b1);
      bus_read(RW_A, rd);
      check("rx_simul_byte", rd, 32'h66);
      bus_read(STAT_A, rd);
      check("rx_simul_status", rd, 32'h81);
      address = RW_A; read_enable = 1'b1;
      tick();
      read_enable = 1'b0; address = 32'h0;

      // Reset while a byte is in flight and two are queued
      busy_len = 20; pulses = 0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h31 + 8'(k));
         bus_write(RW_A, 32'h31 + k);
      end
      repeat (5) tick();
      bus_read(STAT_A, rd);
      check("midxfer_status", rd, 32'h40);
      check("midxfer_pulse_count", pulses, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      pulses = 0;
      repeat (30) tick();
      check("post_reset_pulses", pulses, 0);
      bus_read(STAT_A, rd);
      check("post_reset_status", rd, 32'h80);
      check("post_reset_uart_data", {24'h0, uart_data}, 32'h0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller between the core's data bus and the UART transceiver. It buffers core writes in a TX FIFO and sequences them into the UART one byte at a time, using the UART `busy` handshake. It also captures received bytes with valid/overrun flags and owns the baud divisor register. The top level uses `hit` to select `read_data` over data memory and to gate the data-memory write enable.

## Interface
Parameters:
- TX_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- UART_RW_ADDR, 32'h10010000: TX push on write, RX byte on read.
- UART_STATUS_ADDR, 32'h10010005: status register.
- BAUD_ADDR, 32'h10010100: baud divisor register.
- BAUD_RESET, 16'h0003: reset value of baud_max.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- address  in  32  core data address.
- write_data  in  32  core store data.
- write_enable  in  1  core store strobe.
- read_enable  in  1  core load strobe; qualifies read side effects.
- read_data  out  32  combinational read data for mapped addresses; 0 otherwise.
- hit  out  1  combinational; address equals one of the three mapped addresses.
- uart_data  out  8  byte presented to the UART.
- uart_write_enable  out  1  one-cycle start pulse to the UART.
- uart_busy  in  1  UART transmitter busy.
- uart_rx_data  in  8  received byte.
- uart_out_valid  in  1  one-cycle pulse; uart_rx_data is valid.
- baud_max  out  16  baud divisor to the UART.

## Operation
- **Status byte** (read_data[7:0], upper bits 0):
  - [7] tx_empty
  - [6] tx_active (state≠IDLE or FIFO non-empty)
  - [5] tx_full
  - [2] tx_overflow (sticky)
  - [1] rx_overrun (sticky)
  - [0] rx_valid
  - [4:3] read as 0.
- **Write to UART_RW_ADDR:** pushes write_data[7:0]. If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and tx_overflow is set.
- **Write to UART_STATUS_ADDR:** write_data[2]=1 clears tx_overflow; all other bits are ignored.
- **Write to BAUD_ADDR:** baud_max ← write_data[15:0]. A value of 0 is ignored and baud_max keeps its old value.
- **Read of UART_RW_ADDR:** read_data = {24'b0, rx_byte}. With read_enable, rx_valid and rx_overrun are cleared at the clock edge.
- **Read of BAUD_ADDR:** read_data = {16'b0, baud_max}.
- **RX capture on uart_out_valid:**
  - rx_byte ← uart_rx_data and rx_valid ← 1.
  - If rx_valid was already 1 and there is no clearing read in the same cycle, rx_overrun ← 1.
  - If a clearing read coincides with uart_out_valid: the new byte is loaded, rx_valid = 1, rx_overrun = 0.
- **Simultaneous events:** push and pop in the same cycle are both accepted and count is unchanged, including when the FIFO is full.
- **TX state machine:**
  - IDLE: if the FIFO is non-empty, pop the head into uart_data and go to LOAD.
  - LOAD: uart_write_enable = 1 for this cycle only; go to WAIT_BUSY.
  - WAIT_BUSY: when uart_busy = 1, go to WAIT_DONE.
  - WAIT_DONE: when uart_busy = 0, go to IDLE.
- **Pointers and count:** read/write pointers are log2(TX_DEPTH) bits and wrap modulo TX_DEPTH. count is log2(TX_DEPTH)+1 bits. full = (count == TX_DEPTH); empty = (count == 0).

## Timing
- **Reset values:**
  - state IDLE, FIFO empty (pointers and count 0).
  - uart_data 0, uart_write_enable 0.
  - baud_max BAUD_RESET.
  - rx_byte 0; rx_valid, rx_overrun and tx_overflow 0.
- **Reset mid-operation:** any queued or in-flight byte is discarded. The UART shares rst.
- **TX latency:** a store committed at edge N gives IDLE→LOAD at edge N+1 and uart_write_enable high for cycle N+2 with uart_data stable.
- **uart_data** holds the last popped byte until the next pop.
- **Byte spacing:** at least 3 cycles between consecutive uart_write_enable pulses, plus the UART busy time.
- **RX:** flags update at the edge where uart_out_valid is sampled. They are visible combinationally on read_data in the next cycle.
- **read_data and hit** are purely combinational from address and registers; they have no read latency.

## Test plan
- Reset with baud write: reset, then read status = 8'h80 and read BAUD_ADDR = 3. Write 16'h1234 to BAUD_ADDR → baud_max = 16'h1234. Write 0 → baud_max stays 16'h1234.
- Single byte: write 8'h41 to UART_RW → uart_write_enable pulses exactly 2 cycles later with uart_data = 8'h41. Model uart_busy high for 20 cycles → status[6] = 1 during the busy period, and status = 8'h80 after busy falls.
- FIFO full and overflow: hold uart_busy high, write 5 bytes with TX_DEPTH = 4 → the first byte is popped, the next four fill the FIFO, status[5] = 1. Write a sixth byte → status[2] = 1. Release busy → bytes are emitted in order with no extra pulses. Write status[2] = 1 → the bit clears.
- RX overrun: pulse uart_out_valid with 8'h55, then with 8'hAA, no read → read_data[7:0] = 8'hAA and status[1:0] = 2'b11. A read_enable read of UART_RW → status[1:0] = 2'b00.
- Simultaneous RX and read: uart_out_valid with 8'h66 in the same cycle as a clearing read of the old byte → rx_byte = 8'h66, status[1:0] = 2'b01.
- Reset mid-transfer: assert rst in WAIT_DONE with 2 bytes queued → no further uart_write_enable pulses, and status = 8'h80 after reset.
